card_shoe: RTL
==============

// Module: card_shoe
// PURPOSE
//  Card source upstream of the blackjack game FSM: holds a 52*DECKS card shoe, deals two cards
//  per request without replacement and returns blackjack values (A=1, 2..10, J/Q/K=10).
//  Auto-reshuffles when the shoe runs low. test_sel selects scripted hands for directed benches.
// PARAMETERS
//  DECKS         1         decks in shoe, 1..4; per-rank count = 4*DECKS
//  RESHUFFLE_AT  15        at draw acceptance, cards_left < RESHUFFLE_AT forces reshuffle first
//  LFSR_SEED     16'hACE1  LFSR reset value, must be nonzero
// PORTS
//  clk           in   1  system clock
//  reset         in   1  synchronous, active-high reset
//  draw_req      in   1  one-cycle pulse: request two cards
//  shuffle_req   in   1  one-cycle pulse: refill shoe
//  test_sel      in   3  0 = random deal; 1..7 = scripted hand pair from package table
//  ready         out  1  high in IDLE with no pending shuffle
//  card_valid    out  1  one-cycle pulse: card outputs valid
//  card1_value   out  4  value of first card, 1..10
//  card2_value   out  4  value of second card, 1..10
//  card1_rank    out  4  rank of first card, 0=A .. 12=K, for display
//  card2_rank    out  4  rank of second card
//  cards_left    out  8  cards remaining in shoe
//  reshuffled    out  1  one-cycle pulse when a refill completes
// BEHAVIOUR
//  Reset values: all rank counts 4*DECKS; cards_left = 52*DECKS; LFSR = LFSR_SEED.
//   All card outputs 0; card_valid = 0; reshuffled = 0; ready = 1 from the first cycle after reset.
//  LFSR: 16-bit Fibonacci LFSR, taps 16,14,13,11. Advances every cycle, including during reset release.
//  Candidate rank: r = lfsr[3:0]; if r >= 13, r = r - 13.
//  FSM states: IDLE, SHUFFLE, DRAW1, PROBE1, DRAW2, PROBE2, DONE.
//   IDLE + draw_req:
//    - go to SHUFFLE if shuffle pending, shuffle_req is high this cycle, or cards_left < RESHUFFLE_AT;
//    - else go to DRAW1. ready falls the next cycle.
//   IDLE + shuffle_req alone -> SHUFFLE. SHUFFLE -> IDLE.
//   SHUFFLE (1 cycle): counts and cards_left set to full, reshuffled = 1, pending flag cleared.
//    Returns to DRAW1 if a draw was accepted, else to IDLE.
//   DRAW1: take candidate r.
//    - count[r] != 0: decrement count[r] and cards_left, latch card1, go to DRAW2.
//    - count[r] == 0: go to PROBE1.
//   PROBE1: r = (r == 12) ? 0 : r + 1; one rank tested per cycle, at most 12 probes.
//    Shoe is never empty here, because a draw always has >= RESHUFFLE_AT >= 2 cards.
//   DRAW2/PROBE2: same as DRAW1/PROBE1, latch card2, then go to DONE.
//    count/cards_left updated by card1 are visible to card2 (same card not dealt twice).
//   DONE: card_valid = 1 for exactly one cycle, card outputs hold until the next DONE, -> IDLE.
//  Latency: draw_req to card_valid = 3 cycles minimum (IDLE->DRAW1->DRAW2->DONE), +1 per probe,
//   +1 if a reshuffle is inserted. Worst case 3 + 24 + 1 = 28 cycles.
//  Value map: rank 0 -> 1; ranks 1..9 -> 2..10; ranks 10..12 -> 10.
//  test_sel != 0: ranks come from SCRIPT[test_sel] as a {rank1, rank2} pair. Counts are still
//   decremented; if a scripted rank has count 0, the shoe probes as in random mode. Latency unchanged.
//  draw_req outside IDLE is ignored; no queueing; the requester waits for ready.
//  shuffle_req outside IDLE is latched as pending; SHUFFLE runs on return to IDLE; ready stays low meanwhile.
//  draw_req and shuffle_req in the same IDLE cycle: SHUFFLE first, then the draw.
//  reset mid-operation: operation aborted, no card_valid; shoe refilled to full.
//  Width: counts 5 bits (max 16); cards_left 8 bits (max 208); no wrap possible by construction.
// STRUCTURE
//  Package card_pkg:
//   - rank_t (4-bit), RANK_ACE=0, RANK_KING=12, NUM_RANKS=13;
//   - rank_to_value() function;
//   - SCRIPT[1:7] rank-pair table, e.g. 1: {A,K}, 2: {8,8}, 3: {10,6}.
//  Sub-module card_lfsr (free-running 16-bit LFSR, seed parameter). FSM and rank counts stay in card_shoe.
// TESTING
//  1. reset, then draw_req with test_sel=1 -> card_valid at cycle 3;
//     card1_rank=0, card1_value=1, card2_rank=12, card2_value=10; cards_left=50.
//  2. test_sel=2, draw 3 times (6 cards). Count for rank 7 (the 8) reaches 0 on the 2nd draw.
//     3rd draw probes to rank 8: card values 9,9; each probe adds one cycle of latency.
//  3. Random mode, draw until cards_left=14, then draw_req -> reshuffled pulse one cycle before DRAW1;
//     cards_left=50 after card_valid.
//  4. Random mode, 26 draws with RESHUFFLE_AT=0 (param override) -> 52 cards out, each rank dealt exactly 4 times.
//  5. draw_req and shuffle_req in the same cycle -> SHUFFLE then card_valid at cycle 4;
//     draw_req mid-DRAW1 is ignored (one card_valid only).
//  6. reset asserted in PROBE1 -> no card_valid; cards_left=52 and ready=1 on the cycle after reset drops.

Source files
------------

// File: rtl/card_pkg.sv
// rtl/card_pkg.sv - card rank types, rank/value mapping and the scripted hand table
package card_pkg;

  typedef logic [3:0] rank_t;

  localparam rank_t RANK_ACE  = 4'd0;
  localparam rank_t RANK_KING = 4'd12;
  localparam int    NUM_RANKS = 13;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHUFFLE,
    ST_DRAW1,
    ST_PROBE1,
    ST_DRAW2,
    ST_PROBE2,
    ST_DONE
  } state_t;

  typedef struct packed {
    rank_t r1;
    rank_t r2;
  } pair_t;

  // {A,K} {8,8} {10,6} {A,A} {K,Q} {5,6} {J,A}
  localparam pair_t SCRIPT [1:7] = '{
    '{4'd0,  4'd12},
    '{4'd7,  4'd7},
    '{4'd9,  4'd5},
    '{4'd0,  4'd0},
    '{4'd12, 4'd11},
    '{4'd4,  4'd5},
    '{4'd10, 4'd0}
  };

  function automatic logic [3:0] rank_to_value(rank_t r);
    if (r == RANK_ACE) return 4'd1;
    else if (r <= 4'd9) return r + 4'd1;
    else return 4'd10;
  endfunction

  function automatic rank_t next_rank(rank_t r);
    return (r == RANK_KING) ? RANK_ACE : r + 4'd1;
  endfunction

endpackage

// File: rtl/card_shoe_if.sv
// rtl/card_shoe_if.sv - request/deal bundle between the game FSM and the card shoe
interface card_shoe_if;
  import card_pkg::*;

  logic        draw_req;
  logic        shuffle_req;
  logic [2:0]  test_sel;
  logic        ready;
  logic        card_valid;
  logic [3:0]  card1_value;
  logic [3:0]  card2_value;
  rank_t       card1_rank;
  rank_t       card2_rank;
  logic [7:0]  cards_left;
  logic        reshuffled;

  modport master (
    output draw_req, shuffle_req, test_sel,
    input  ready, card_valid, card1_value, card2_value,
           card1_rank, card2_rank, cards_left, reshuffled
  );

  modport slave (
    input  draw_req, shuffle_req, test_sel,
    output ready, card_valid, card1_value, card2_value,
           card1_rank, card2_rank, cards_left, reshuffled
  );
endinterface

// File: rtl/card_lfsr.sv
// rtl/card_lfsr.sv - free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), low nibble out
module card_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] rnd
);
  logic [15:0] state;

  always_ff @(posedge clk) begin
    if (reset) state <= SEED;
    else       state <= {state[14:0], state[15] ^ state[13] ^ state[12] ^ state[10]};
  end

  assign rnd = state[3:0];
endmodule

// File: rtl/card_shoe.sv
// rtl/card_shoe.sv - multi-deck shoe dealing two cards per request without replacement
module card_shoe
  import card_pkg::*;
#(
  parameter int          DECKS        = 1,
  parameter int          RESHUFFLE_AT = 15,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input logic        clk,
  input logic        reset,
  card_shoe_if.slave bus
);
  localparam logic [4:0] FULL_COUNT = 5'(4 * DECKS);
  localparam logic [7:0] FULL_LEFT  = 8'(52 * DECKS);

  state_t     state, next_state;
  logic [4:0] count [NUM_RANKS];
  logic [7:0] left;
  logic       pending, draw_after;
  logic [2:0] sel_q;
  rank_t      probe_r, c1_r, base_r, test_r, cand_r;
  logic [3:0] rnd;
  logic       hit, low;

  card_lfsr #(.SEED(LFSR_SEED)) u_lfsr (.clk(clk), .reset(reset), .rnd(rnd));

  assign cand_r = (rnd >= 4'd13) ? rnd - 4'd13 : rnd;
  assign low    = int'(left) < RESHUFFLE_AT;

  // Rank under test this cycle: fresh candidate in DRAWx, next rank up in PROBEx.
  always_comb begin
    base_r = cand_r;
    if (sel_q != 3'd0) base_r = (state == ST_DRAW2) ? SCRIPT[sel_q].r2 : SCRIPT[sel_q].r1;
    test_r = (state == ST_PROBE1 || state == ST_PROBE2) ? next_rank(probe_r) : base_r;
    hit    = count[test_r] != 5'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE: begin
        if (bus.draw_req)
          next_state = (pending || bus.shuffle_req || low) ? ST_SHUFFLE : ST_DRAW1;
        else if (bus.shuffle_req || pending)
          next_state = ST_SHUFFLE;
      end
      ST_SHUFFLE:          next_state = draw_after ? ST_DRAW1 : ST_IDLE;
      ST_DRAW1, ST_PROBE1: next_state = hit ? ST_DRAW2 : ST_PROBE1;
      ST_DRAW2, ST_PROBE2: next_state = hit ? ST_DONE : ST_PROBE2;
      ST_DONE:             next_state = ST_IDLE;
      default:             next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_RANKS; i++) count[i] <= FULL_COUNT;
      left            <= FULL_LEFT;
      pending         <= 1'b0;
      draw_after      <= 1'b0;
      sel_q           <= 3'd0;
      probe_r         <= RANK_ACE;
      c1_r            <= RANK_ACE;
      bus.card1_rank  <= RANK_ACE;
      bus.card2_rank  <= RANK_ACE;
      bus.card1_value <= 4'd0;
      bus.card2_value <= 4'd0;
    end else begin
      if (bus.shuffle_req && state != ST_IDLE && state != ST_SHUFFLE) pending <= 1'b1;
      case (state)
        ST_IDLE: begin
          draw_after <= bus.draw_req;
          if (bus.draw_req) sel_q <= bus.test_sel;
        end
        ST_SHUFFLE: begin
          for (int i = 0; i < NUM_RANKS; i++) count[i] <= FULL_COUNT;
          left    <= FULL_LEFT;
          pending <= 1'b0;
        end
        ST_DRAW1, ST_PROBE1: begin
          probe_r <= test_r;
          if (hit) begin
            count[test_r] <= count[test_r] - 5'd1;
            left          <= left - 8'd1;
            c1_r          <= test_r;
          end
        end
        ST_DRAW2, ST_PROBE2: begin
          probe_r <= test_r;
          // Outputs only change on entry to DONE so a dealt hand stays stable until the next one.
          if (hit) begin
            count[test_r]   <= count[test_r] - 5'd1;
            left            <= left - 8'd1;
            bus.card1_rank  <= c1_r;
            bus.card2_rank  <= test_r;
            bus.card1_value <= rank_to_value(c1_r);
            bus.card2_value <= rank_to_value(test_r);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.ready      = (state == ST_IDLE) && !pending;
    bus.card_valid = (state == ST_DONE);
    bus.reshuffled = (state == ST_SHUFFLE);
  end

  assign bus.cards_left = left;
endmodule
